// File: rtl/imem_loader.sv
// imem_loader: receives an instruction image as a byte stream and writes it
// into instruction memory, holding the core in reset until the image has
// been received and its checksum matches.
//
// Stream: LEN_LO, LEN_HI (little-endian 16-bit word count N),
//         4*N payload bytes (little-endian words), XOR checksum byte.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_start             one-cycle load request (honoured in IDLE/DONE/ERROR)
//   i_byte/_valid       stream byte and qualifier
//   o_byte_ready        loader takes i_byte this cycle
//   o_imem_wr_en/addr/data  one-cycle instruction-memory write
//   o_core_rst_n        core reset, high only after a good load
//   o_busy/done/error   status flags
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_imem_wr_en,
  output logic [ADDR_W-1:0] o_imem_wr_addr,
  output logic [31:0]       o_imem_wr_data,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = ADDR_W + 1;  // word count reaches 2^ADDR_W

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [CW-1:0] word_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;
  logic [23:0]   word_buf;  // first three bytes of the word in progress

  logic        busy, accept, start_ok, tmo_hit, last_word, too_long;
  logic [15:0] n_rx;

  assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHECK);
  assign accept   = i_byte_valid && busy;
  assign start_ok = i_start && ((state == S_IDLE) || (state == S_DONE) ||
                                (state == S_ERROR));
  assign n_rx     = {i_byte, len_lo};
  assign too_long = 32'(n_rx) > (32'd1 << ADDR_W);
  // Error is taken on the same edge the counter lands on TIMEOUT.
  assign tmo_hit  = busy && !accept && (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (i_start) state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (accept)       state_nxt = S_LEN_HI;
        else if (tmo_hit) state_nxt = S_ERROR;
      S_LEN_HI:
        if (accept) begin
          if (n_rx == 16'd0) state_nxt = S_CHECK;
          else if (too_long) state_nxt = S_ERROR;
          else               state_nxt = S_DATA;
        end else if (tmo_hit) state_nxt = S_ERROR;
      S_DATA:
        if (accept) begin
          if (byte_cnt == 2'd3 && last_word) state_nxt = S_CHECK;
        end else if (tmo_hit) state_nxt = S_ERROR;
      S_CHECK:
        if (accept)       state_nxt = (i_byte == csum) ? S_DONE : S_ERROR;
        else if (tmo_hit) state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_byte_ready = busy;
    o_busy       = busy;
    o_done       = (state == S_DONE);
    o_error      = (state == S_ERROR);
    o_core_rst_n = (state == S_DONE);
  end

  // Datapath: counters, checksum, word assembly and the registered write.
  // The write pulse is independent of the next state, so a word completed
  // on the cycle the FSM errors out is still written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo         <= '0;
      len            <= '0;
      word_cnt       <= '0;
      byte_cnt       <= '0;
      csum           <= '0;
      tmo_cnt        <= '0;
      word_buf       <= '0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
    end else begin
      o_imem_wr_en <= 1'b0;
      if (start_ok) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        csum     <= '0;
        tmo_cnt  <= '0;
      end else if (busy) begin
        if (accept)                       tmo_cnt <= '0;
        else if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
        if (accept) begin
          case (state)
            S_LEN_LO: len_lo <= i_byte;
            S_LEN_HI: len    <= n_rx;
            S_DATA: begin
              csum     <= csum ^ i_byte;
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0: word_buf[7:0]   <= i_byte;
                2'd1: word_buf[15:8]  <= i_byte;
                2'd2: word_buf[23:16] <= i_byte;
                default: begin
                  o_imem_wr_en   <= 1'b1;
                  o_imem_wr_addr <= word_cnt[ADDR_W-1:0];
                  o_imem_wr_data <= {i_byte, word_buf};
                  word_cnt       <= word_cnt + 1'b1;
                end
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=8, TIMEOUT=16). Inputs change and
// outputs are checked 1ns after the falling edge; a monitor logs every
// write pulse seen on the falling edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready, o_imem_wr_en, o_core_rst_n, o_busy, o_done, o_error;
  logic [7:0]  o_imem_wr_addr;
  logic [31:0] o_imem_wr_data;

  int checks = 0;
  int errors = 0;

  int          wr_n = 0;
  logic [7:0]  wa [0:15];
  logic [31:0] wd [0:15];

  imem_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_imem_wr_en(o_imem_wr_en), .o_imem_wr_addr(o_imem_wr_addr),
    .o_imem_wr_data(o_imem_wr_data), .o_core_rst_n(o_core_rst_n),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (o_imem_wr_en) begin
      if (wr_n < 16) begin
        wa[wr_n] <= o_imem_wr_addr;
        wd[wr_n] <= o_imem_wr_data;
      end
      wr_n <= wr_n + 1;
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish before 100us");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    i_byte = b;
    i_byte_valid = 1'b1;
    tick(1);
    i_byte_valid = 1'b0;
  endtask

  // status = {ready, wr_en, core_rst_n, busy, done, error}
  task automatic chk_status(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {o_byte_ready, o_imem_wr_en, o_core_rst_n, o_busy, o_done, o_error};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got status %b, want %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_byte_valid = 1'b1;
    i_byte = 8'hA5;
    tick(3);
    chk_status("reset_status", 6'b000000);
    checks++;
    if (o_imem_wr_addr !== 8'h00 || o_imem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wr_bus: got %h/%h, want 00/00000000", o_imem_wr_addr, o_imem_wr_data);
    end
    rst = 1'b1;
    tick(3);
    chk_status("idle_after_reset", 6'b000000);
    i_byte_valid = 1'b0;
  endtask

  task automatic test_load_ok();
    int base;
    base = wr_n;
    start();
    chk_status("load_started", 6'b100100);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk_status("word0_pulse", 6'b110100);
    checks++;
    if (o_imem_wr_addr !== 8'd0 || o_imem_wr_data !== 32'h00000013) begin
      errors++;
      $display("FAIL word0_bus: got %h/%h, want 00/00000013", o_imem_wr_addr, o_imem_wr_data);
    end
    send(8'h93);
    chk_status("pulse_one_cycle", 6'b100100);
    send(8'h00); send(8'h10); send(8'h00);
    chk_status("word1_pulse", 6'b110100);
    // XOR of payload 13^93^10 = 90
    send(8'h90);
    chk_status("load_done", 6'b001010);
    checks++;
    if (wr_n - base !== 2 || wa[base] !== 8'd0 || wd[base] !== 32'h00000013 ||
        wa[base+1] !== 8'd1 || wd[base+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL load_writes: got n=%0d %h:%h %h:%h, want n=2 00:00000013 01:00100093",
               wr_n - base, wa[base], wd[base], wa[base+1], wd[base+1]);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    base = wr_n;
    start();  // from DONE: core reset falls on this edge
    chk_status("restart_from_done", 6'b100100);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    send(8'h00);
    chk_status("bad_cksum_error", 6'b000001);
    checks++;
    if (wr_n - base !== 2 || wd[base+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL bad_cksum_writes: got n=%0d d1=%h, want n=2 d1=00100093", wr_n - base, wd[base+1]);
    end
  endtask

  task automatic test_zero_len();
    int base;
    base = wr_n;
    start();
    send(8'h00); send(8'h00);
    chk_status("zero_len_check", 6'b100100);
    send(8'h00);
    chk_status("zero_len_done", 6'b001010);
    checks++;
    if (wr_n !== base) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d, want 0", wr_n - base);
    end
  endtask

  task automatic test_len_bounds();
    int base;
    base = wr_n;
    start();
    send(8'h01); send(8'h01);  // N=257 > 256
    chk_status("len_257_error", 6'b000001);
    tick(2);
    checks++;
    if (wr_n !== base) begin
      errors++;
      $display("FAIL len_257_writes: got %0d, want 0", wr_n - base);
    end
    start();
    send(8'h00); send(8'h01);  // N=256 is allowed
    chk_status("len_256_accepted", 6'b100100);
    i_start = 1'b1;  // ignored while loading
    tick(1);
    i_start = 1'b0;
    chk_status("start_ignored_busy", 6'b100100);
  endtask

  task automatic test_timeout();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    start();
    send(8'h05);
    tick(15);
    chk_status("timeout_not_yet", 6'b100100);
    tick(1);
    chk_status("timeout_error", 6'b000001);
    start();
    chk_status("restart_after_timeout", 6'b100100);
    send(8'h00);  // LEN_LO consumed; LEN_HI follows
    send(8'h00);
    send(8'h00);
    chk_status("restart_completes", 6'b001010);
  endtask

  task automatic test_reset_midload();
    int base;
    base = wr_n;
    start();
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    checks++;
    if (wr_n - base !== 1 || wd[base] !== 32'h44332211) begin
      errors++;
      $display("FAIL midload_word0: got n=%0d d=%h, want n=1 d=44332211", wr_n - base, wd[base]);
    end
    i_byte = 8'h77;
    i_byte_valid = 1'b1;
    rst = 1'b0;  // mid-cycle, well before the next rising edge
    #1;
    chk_status("async_reset_status", 6'b000000);
    checks++;
    if (o_imem_wr_addr !== 8'h00 || o_imem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_bus: got %h/%h, want 00/00000000", o_imem_wr_addr, o_imem_wr_data);
    end
    tick(2);
    i_byte = 8'h88;
    rst = 1'b1;
    tick(4);
    i_byte_valid = 1'b0;
    chk_status("idle_after_abort", 6'b000000);
    checks++;
    if (wr_n - base !== 1) begin
      errors++;
      $display("FAIL abort_no_write: got %0d writes, want 1", wr_n - base);
    end
  endtask

  initial begin
    test_reset();
    test_load_ok();
    test_bad_checksum();
    test_zero_len();
    test_len_bounds();
    test_timeout();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
